// File: rtl/player_input_cond_pkg.sv
// Shared types for the player input conditioning path.
package player_input_cond_pkg;

    // Direction currently granted to one player.
    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    localparam int NUM_PLAYERS = 2;

endpackage : player_input_cond_pkg

// File: rtl/player_input_cond_checker.sv
// Property checks on the conditioned outputs.
module player_input_cond_checker (
    input logic clk,
    input logic rst,
    input logic m_left,
    input logic m_right,
    input logic gpio_left,
    input logic gpio_right
);
    // A player must never be told to move both ways at once.
    p1_exclusive: assert property (@(posedge clk) disable iff (rst) !(m_left && m_right));
    p2_exclusive: assert property (@(posedge clk) disable iff (rst) !(gpio_left && gpio_right));

    // Outputs are cleared on any edge where reset is sampled.
    rst_clears: assert property (@(posedge clk) rst |=> !(m_left || m_right || gpio_left || gpio_right));

endmodule : player_input_cond_checker

// File: rtl/player_input_cond_debounce_ch.sv
// One input channel: 2-FF synchroniser followed by a saturating-free
// debounce counter. dout only flips once the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_r;
    logic             s2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-stage synchroniser; also used for the already-synchronous mouse
    // flags so that both players see identical latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
        end
    end

    // Debounce: count consecutive disagreeing cycles, restart on any agreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (s2_r == stable_r) begin
            stable_r <= stable_r;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= s2_r;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            stable_r <= stable_r;
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign dout = stable_r;

endmodule : debounce_ch

// File: rtl/player_input_cond.sv
// Conditions raw left/right requests for both players: synchronise,
// debounce, then last-pressed-wins arbitration per player so that the
// movement controller never sees both directions of one player.
module player_input_cond
    import player_input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic m_left_raw,
    input  logic m_right_raw,
    input  logic gpio_left_raw,
    input  logic gpio_right_raw,
    output logic m_left,
    output logic m_right,
    output logic gpio_left,
    output logic gpio_right
);
    // Index 0 is player 1 (mouse), index 1 is player 2 (GPIO).
    logic [NUM_PLAYERS-1:0] raw_left_s;
    logic [NUM_PLAYERS-1:0] raw_right_s;
    logic [NUM_PLAYERS-1:0] stable_left_s;
    logic [NUM_PLAYERS-1:0] stable_right_s;
    logic [NUM_PLAYERS-1:0] left_q_s;
    logic [NUM_PLAYERS-1:0] right_q_s;

    assign raw_left_s  = {gpio_left_raw,  m_left_raw};
    assign raw_right_s = {gpio_right_raw, m_right_raw};

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        dir_t last_r;
        dir_t last_nxt_s;
        logic prev_left_r;
        logic prev_right_r;
        logic left_out_r;
        logic right_out_r;
        logic rise_left_s;
        logic rise_right_s;

        debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
            .clk  (clk),
            .rst  (rst),
            .din  (raw_left_s[p]),
            .dout (stable_left_s[p])
        );

        debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
            .clk  (clk),
            .rst  (rst),
            .din  (raw_right_s[p]),
            .dout (stable_right_s[p])
        );

        assign rise_left_s  = stable_left_s[p]  & ~prev_left_r;
        assign rise_right_s = stable_right_s[p] & ~prev_right_r;

        // Next granted direction: newest press wins, right wins a tie,
        // release of the winner hands over to a still-held opposite.
        always_comb begin
            last_nxt_s = last_r;
            if (!stable_left_s[p] && !stable_right_s[p]) begin
                last_nxt_s = DIR_NONE;
            end else if (rise_right_s) begin
                last_nxt_s = DIR_RIGHT;
            end else if (rise_left_s) begin
                last_nxt_s = DIR_LEFT;
            end else if ((last_r == DIR_RIGHT) && !stable_right_s[p]) begin
                last_nxt_s = DIR_LEFT;
            end else if ((last_r == DIR_LEFT) && !stable_left_s[p]) begin
                last_nxt_s = DIR_RIGHT;
            end else if (last_r == DIR_NONE) begin
                last_nxt_s = stable_right_s[p] ? DIR_RIGHT : DIR_LEFT;
            end else begin
                last_nxt_s = last_r;
            end
        end

        // Arbitration state, edge-detect history and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                last_r       <= DIR_NONE;
                prev_left_r  <= 1'b0;
                prev_right_r <= 1'b0;
                left_out_r   <= 1'b0;
                right_out_r  <= 1'b0;
            end else begin
                last_r       <= last_nxt_s;
                prev_left_r  <= stable_left_s[p];
                prev_right_r <= stable_right_s[p];
                left_out_r   <= (last_nxt_s == DIR_LEFT);
                right_out_r  <= (last_nxt_s == DIR_RIGHT);
            end
        end

        assign left_q_s[p]  = left_out_r;
        assign right_q_s[p] = right_out_r;
    end

    assign m_left     = left_q_s[0];
    assign m_right    = right_q_s[0];
    assign gpio_left  = left_q_s[1];
    assign gpio_right = right_q_s[1];

    player_input_cond_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .m_left     (m_left),
        .m_right    (m_right),
        .gpio_left  (gpio_left),
        .gpio_right (gpio_right)
    );

endmodule : player_input_cond

// File: tb/tb_player_input_cond.sv
// Directed bench for player_input_cond with a short debounce window,
// plus a randomised run against a behavioural reference model.
module tb_player_input_cond;
    localparam int D   = 8;
    localparam int LAT = D + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_left_raw = 1'b0, m_right_raw = 1'b0;
    logic gpio_left_raw = 1'b0, gpio_right_raw = 1'b0;
    logic m_left, m_right, gpio_left, gpio_right;

    int checks = 0;
    int failures = 0;

    // Behavioural model state; channel 0 m_left, 1 m_right, 2 gpio_left, 3 gpio_right.
    bit [3:0] md_s1, md_s2, md_st, md_prev, md_out;
    int       md_cnt [4];
    int       md_last[2];   // 0 none, 1 left, 2 right

    player_input_cond #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .m_left_raw     (m_left_raw),
        .m_right_raw    (m_right_raw),
        .gpio_left_raw  (gpio_left_raw),
        .gpio_right_raw (gpio_right_raw),
        .m_left         (m_left),
        .m_right        (m_right),
        .gpio_left      (gpio_left),
        .gpio_right     (gpio_right)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input bit [3:0] v);
        m_left_raw     = v[0];
        m_right_raw    = v[1];
        gpio_left_raw  = v[2];
        gpio_right_raw = v[3];
    endtask

    task automatic reset_dut();
        set_raw(4'b0000);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_raw(4'b1111);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({gpio_right, gpio_left, m_right, m_left} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_first_edge got=%b want=0000", {gpio_right, gpio_left, m_right, m_left});
        end
        tick(4);
        checks++;
        if ({gpio_right, gpio_left, m_right, m_left} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held got=%b want=0000", {gpio_right, gpio_left, m_right, m_left});
        end
        rst = 1'b0;
        tick(LAT - 1);
        checks++;
        if ({gpio_right, gpio_left, m_right, m_left} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release_early got=%b want=0000", {gpio_right, gpio_left, m_right, m_left});
        end
        tick(1);
        checks++;
        if ({gpio_right, gpio_left, m_right, m_left} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_release_tie got=%b want=1010", {gpio_right, gpio_left, m_right, m_left});
        end
    endtask

    task automatic test_glitch();
        reset_dut();
        gpio_left_raw = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            checks++;
            if (gpio_left !== 1'b0) begin failures++; $display("FAIL glitch_hi1 cyc=%0d got=%b want=0", i, gpio_left); end
        end
        gpio_left_raw = 1'b0;
        tick(2);
        checks++;
        if (gpio_left !== 1'b0) begin failures++; $display("FAIL glitch_lo got=%b want=0", gpio_left); end
        gpio_left_raw = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            tick(1);
            checks++;
            if (gpio_left !== 1'b0) begin failures++; $display("FAIL glitch_hold_early cyc=%0d got=%b want=0", i, gpio_left); end
        end
        tick(1);
        checks++;
        if ({gpio_right, gpio_left} !== 2'b01) begin
            failures++;
            $display("FAIL glitch_hold_rise got=%b want=01", {gpio_right, gpio_left});
        end
    endtask

    task automatic test_bounce();
        reset_dut();
        for (int seg = 0; seg < 10; seg++) begin
            m_right_raw = ~seg[0];
            for (int i = 0; i < 3; i++) begin
                tick(1);
                checks++;
                if (m_right !== 1'b0) begin failures++; $display("FAIL bounce_quiet seg=%0d got=%b want=0", seg, m_right); end
            end
        end
        m_right_raw = 1'b1;
        tick(LAT - 1);
        checks++;
        if (m_right !== 1'b0) begin failures++; $display("FAIL bounce_early got=%b want=0", m_right); end
        tick(1);
        checks++;
        if ({m_right, m_left} !== 2'b10) begin failures++; $display("FAIL bounce_rise got=%b want=10", {m_right, m_left}); end
    endtask

    task automatic test_last_wins();
        reset_dut();
        gpio_right_raw = 1'b1;
        tick(LAT);
        checks++;
        if ({gpio_right, gpio_left} !== 2'b10) begin failures++; $display("FAIL lw_right_only got=%b want=10", {gpio_right, gpio_left}); end
        gpio_left_raw = 1'b1;
        tick(LAT - 1);
        checks++;
        if ({gpio_right, gpio_left} !== 2'b10) begin failures++; $display("FAIL lw_before_left got=%b want=10", {gpio_right, gpio_left}); end
        tick(1);
        checks++;
        if ({gpio_right, gpio_left} !== 2'b01) begin failures++; $display("FAIL lw_left_wins got=%b want=01", {gpio_right, gpio_left}); end
        gpio_left_raw = 1'b0;
        tick(LAT - 1);
        checks++;
        if ({gpio_right, gpio_left} !== 2'b01) begin failures++; $display("FAIL lw_before_handover got=%b want=01", {gpio_right, gpio_left}); end
        tick(1);
        checks++;
        if ({gpio_right, gpio_left} !== 2'b10) begin failures++; $display("FAIL lw_handover got=%b want=10", {gpio_right, gpio_left}); end
        checks++;
        if ({m_right, m_left} !== 2'b00) begin failures++; $display("FAIL lw_p1_idle got=%b want=00", {m_right, m_left}); end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        set_raw(4'b1111);
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if ({gpio_right, gpio_left, m_right, m_left} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_cleared got=%b want=0000", {gpio_right, gpio_left, m_right, m_left});
        end
        tick(LAT - 1);
        checks++;
        if ({gpio_right, gpio_left, m_right, m_left} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_early got=%b want=0000", {gpio_right, gpio_left, m_right, m_left});
        end
        tick(1);
        checks++;
        if ({gpio_right, gpio_left, m_right, m_left} !== 4'b1010) begin
            failures++;
            $display("FAIL midrst_rise got=%b want=1010", {gpio_right, gpio_left, m_right, m_left});
        end
    endtask

    // Advance the reference model by one rising edge.
    task automatic model_edge(input bit [3:0] raw, input bit r);
        int nl;
        int li, ri;
        if (r) begin
            md_s1 = 4'b0; md_s2 = 4'b0; md_st = 4'b0; md_prev = 4'b0; md_out = 4'b0;
            for (int c = 0; c < 4; c++) md_cnt[c] = 0;
            md_last[0] = 0; md_last[1] = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                li = 2 * p;
                ri = 2 * p + 1;
                nl = md_last[p];
                if (!md_st[li] && !md_st[ri])            nl = 0;
                else if (md_st[ri] && !md_prev[ri])      nl = 2;
                else if (md_st[li] && !md_prev[li])      nl = 1;
                else if (nl == 2 && !md_st[ri])          nl = 1;
                else if (nl == 1 && !md_st[li])          nl = 2;
                else if (nl == 0)                        nl = md_st[ri] ? 2 : 1;
                md_last[p] = nl;
                md_out[li] = (nl == 1);
                md_out[ri] = (nl == 2);
            end
            md_prev = md_st;
            for (int c = 0; c < 4; c++) begin
                if (md_s2[c] == md_st[c]) md_cnt[c] = 0;
                else if (md_cnt[c] == D - 1) begin md_st[c] = md_s2[c]; md_cnt[c] = 0; end
                else md_cnt[c] = md_cnt[c] + 1;
            end
            md_s2 = md_s1;
            md_s1 = raw;
        end
    endtask

    task automatic test_random();
        bit [3:0] raw_v;
        int hold[4];
        raw_v = 4'b0000;
        for (int c = 0; c < 4; c++) hold[c] = $urandom_range(20, 1);
        set_raw(raw_v);
        rst = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            model_edge({gpio_right_raw, gpio_left_raw, m_right_raw, m_left_raw}, rst);
            #1;
            checks++;
            if ({gpio_right, gpio_left, m_right, m_left} !== md_out) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, {gpio_right, gpio_left, m_right, m_left}, md_out);
            end
            checks++;
            if ((m_left & m_right) !== 1'b0 || (gpio_left & gpio_right) !== 1'b0) begin
                failures++;
                $display("FAIL random_exclusive cyc=%0d got=%b want=no_pair", cyc, {gpio_right, gpio_left, m_right, m_left});
            end
            if (cyc == 1) rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    raw_v[c] = ~raw_v[c];
                    hold[c]  = $urandom_range(20, 1);
                end
            end
            set_raw(raw_v);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_bounce();
        test_last_wins();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_player_input_cond
